// File: rtl/sound_pkg.sv
// sound_pkg
// Shared definitions for the sawtooth voice path.
//   phase_state_t : phase generator FSM states (IDLE / RUN / STOP)
//   INDEX_W       : width of the sawtooth table index, shared with the table
//   IDLE_INDEX    : table index parked on while the voice is silent (mid-scale)
package sound_pkg;

  localparam int INDEX_W = 4;

  localparam logic [INDEX_W-1:0] IDLE_INDEX = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } phase_state_t;

endpackage

// File: rtl/sample_tick_div.sv
// sample_tick_div
// Free-running sample-rate divider. Counts 0..CLK_DIV-1 and wraps; tick is
// high during the cycle in which the count sits at CLK_DIV-1.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; returns the count to 0
//   tick  : one-cycle strobe, once every CLK_DIV cycles
// Parameters:
//   CLK_DIV : clk cycles per sample period (must be >= 2)
module sample_tick_div #(
  parameter int CLK_DIV = 2083
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  // The counter wraps straight from LAST to zero so the period is exactly
  // CLK_DIV cycles even when CLK_DIV is not a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/sawtooth_phase_gen.sv
// sawtooth_phase_gen
// Phase accumulator feeding the sawtooth look-up table. Each sample period the
// phase advances by the current tuning word; the top INDEX_W bits form the
// table index. New tuning words arrive over a valid/ready port and are held in
// a one-entry pending register until the next sample tick. A zero word is a
// stop request: the ramp runs on until it next crosses mid-scale, then parks
// there so note-off is click-free.
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-high
//   note_valid  : tuning word offered
//   note_ready  : pending register empty (and not in reset)
//   note_tune   : phase increment per sample, 0 = stop request
//   index       : registered table index (phase MSBs)
//   sample_tick : one-cycle pulse in the cycle index is new
//   active      : high while the FSM is not IDLE
//   hard_sync   : only with PHASE_HARD_SYNC_EN; zeroes the phase on a tick
// Parameters:
//   PHASE_W : accumulator width (must be >= 5)
//   CLK_DIV : clk cycles per sample period (must be >= 2)
// Build option:
//   PHASE_HARD_SYNC_EN : adds the hard_sync input
module sawtooth_phase_gen
  import sound_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int CLK_DIV = 2083
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [PHASE_W-1:0] note_tune,
  output logic [INDEX_W-1:0] index,
  output logic               sample_tick,
  output logic               active
`ifdef PHASE_HARD_SYNC_EN
  ,
  input  logic               hard_sync
`endif
);

  localparam logic [PHASE_W-1:0] MID = PHASE_W'(1) << (PHASE_W - 1);

  logic               tick;
  logic               sync;
  logic [PHASE_W-1:0] pending;
  logic               pending_valid;
  logic [PHASE_W-1:0] tune;
  logic [PHASE_W-1:0] tune_next;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic [PHASE_W-1:0] stepped;
  logic               pend_load;
  logic               pend_stop;
  phase_state_t       state;
  phase_state_t       state_next;

  sample_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

`ifdef PHASE_HARD_SYNC_EN
  assign sync = hard_sync;
`else
  assign sync = 1'b0;
`endif

  assign note_ready = !pending_valid && !reset;
  assign active     = (state != IDLE);

  // Next-state logic. Everything is frozen between ticks; on a tick the
  // pending word (if any) is applied. In STOP a new nonzero word takes
  // priority over the mid-scale crossing, and a hard sync suppresses the
  // crossing so the ramp restarts from zero instead of parking.
  always_comb begin
    state_next = state;
    tune_next  = tune;
    phase_next = phase;
    pend_load  = pending_valid && (pending != '0);
    pend_stop  = pending_valid && (pending == '0);
    stepped    = sync ? '0 : (phase + tune);
    if (tick) begin
      case (state)
        IDLE: begin
          phase_next = MID;
          if (pend_load) begin
            tune_next  = pending;
            state_next = RUN;
          end
        end
        RUN: begin
          phase_next = stepped;
          if (pend_load) begin
            tune_next = pending;
          end else if (pend_stop) begin
            state_next = STOP;
          end
        end
        STOP: begin
          phase_next = stepped;
          if (pend_load) begin
            tune_next  = pending;
            state_next = RUN;
          end else if (!sync && !phase[PHASE_W-1] && stepped[PHASE_W-1]) begin
            phase_next = MID;
            state_next = IDLE;
          end
        end
        default: begin
          phase_next = MID;
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, accumulator and output registers. The pending slot is freed on
  // every tick it was full; a transfer can only happen while it is empty, so
  // the two branches never compete.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tune          <= '0;
      phase         <= MID;
      pending       <= '0;
      pending_valid <= 1'b0;
      index         <= IDLE_INDEX;
      sample_tick   <= 1'b0;
    end else begin
      state       <= state_next;
      tune        <= tune_next;
      phase       <= phase_next;
      index       <= phase_next[PHASE_W-1 -: INDEX_W];
      sample_tick <= tick;
      if (tick && pending_valid) begin
        pending_valid <= 1'b0;
      end else if (note_valid && note_ready) begin
        pending       <= note_tune;
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sawtooth_phase_gen.sv
// tb_sawtooth_phase_gen
// Directed bench for sawtooth_phase_gen with PHASE_W = 8 and CLK_DIV = 4.
// A table of per-sample-tick vectors covers start, fractional tuning, stop,
// cancel-stop and stop across the wrap; hand-written sequences cover reset,
// backpressure, mid-note reset and (when built with PHASE_HARD_SYNC_EN) hard sync.
module tb_sawtooth_phase_gen;

  localparam int PHASE_W = 8;
  localparam int CLK_DIV = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               note_valid = 1'b0;
  logic [PHASE_W-1:0] note_tune = '0;
  logic               note_ready;
  logic [3:0]         index;
  logic               sample_tick;
  logic               active;
`ifdef PHASE_HARD_SYNC_EN
  logic               hard_sync = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         send;
    logic [7:0] tune;
    logic [3:0] exp_index;
    bit         exp_active;
  } vec_t;

  vec_t vecs[$];

  sawtooth_phase_gen #(
    .PHASE_W(PHASE_W),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_tune  (note_tune),
    .index      (index),
    .sample_tick(sample_tick),
    .active     (active)
`ifdef PHASE_HARD_SYNC_EN
    ,
    .hard_sync  (hard_sync)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Safety net so the run always ends even if the design locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void add_vec(input bit send, input logic [7:0] tune,
                                  input logic [3:0] idx, input bit act);
    vec_t v;
    v.send       = send;
    v.tune       = tune;
    v.exp_index  = idx;
    v.exp_active = act;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitTick(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 2 * CLK_DIV + 2; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no sample_tick, expected one within %0d cycles",
               name, 2 * CLK_DIV + 2);
    end
  endtask

  task automatic sendNote(input logic [7:0] t);
    bit done;
    done       = 1'b0;
    note_valid = 1'b1;
    note_tune  = t;
    for (int i = 0; i < 4 * CLK_DIV && !done; i++) begin
      if (note_ready) done = 1'b1;
      @(negedge clk);
    end
    note_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL send: got note_ready=0, expected 1 within %0d cycles",
               4 * CLK_DIV);
    end
  endtask

  task automatic applyStimulus(input int n);
    vec_t v;
    bit   seen;
    v = vecs[n];
    if (v.send) sendNote(v.tune);
    waitTick($sformatf("vec%0d tick", n), seen);
    if (seen) begin
      checkOutput($sformatf("vec%0d index", n), 32'(index), 32'(v.exp_index));
      checkOutput($sformatf("vec%0d active", n), 32'(active), 32'(v.exp_active));
    end
  endtask

  initial begin
    int  n;
    int  low;
    bit  seen;

    // Start: idle tick, load 0x10, ramp 9..15, wrap to 0, continue to 3.
    add_vec(0, 8'h00, 4'd8, 0);
    add_vec(1, 8'h10, 4'd8, 1);
    for (int k = 9; k <= 15; k++) add_vec(0, 8'h00, 4'(k), 1);
    for (int k = 0; k <= 3; k++) add_vec(0, 8'h00, 4'(k), 1);
    // Stop at index 3: ramp 4..7, park at 8, stay parked.
    add_vec(1, 8'h00, 4'd4, 1);
    add_vec(0, 8'h00, 4'd5, 1);
    add_vec(0, 8'h00, 4'd6, 1);
    add_vec(0, 8'h00, 4'd7, 1);
    add_vec(0, 8'h00, 4'd8, 0);
    add_vec(0, 8'h00, 4'd8, 0);
    // Zero word while idle is consumed with no effect.
    add_vec(1, 8'h00, 4'd8, 0);
    // Fractional tune 0x08: one index step every two ticks.
    add_vec(1, 8'h08, 4'd8, 1);
    add_vec(0, 8'h00, 4'd8, 1);
    add_vec(0, 8'h00, 4'd9, 1);
    add_vec(0, 8'h00, 4'd9, 1);
    add_vec(0, 8'h00, 4'd10, 1);
    // Cancel stop: 0 then 0x20 before the crossing, then steps of 2.
    add_vec(1, 8'h00, 4'd10, 1);
    add_vec(1, 8'h20, 4'd11, 1);
    add_vec(0, 8'h00, 4'd13, 1);
    add_vec(0, 8'h00, 4'd15, 1);
    add_vec(0, 8'h00, 4'd1, 1);
    add_vec(0, 8'h00, 4'd3, 1);
    add_vec(0, 8'h00, 4'd5, 1);
    add_vec(0, 8'h00, 4'd7, 1);
    add_vec(0, 8'h00, 4'd9, 1);
    add_vec(0, 8'h00, 4'd11, 1);
    add_vec(0, 8'h00, 4'd13, 1);
    // Stop across the all-ones wrap: wrap does not end STOP, crossing does.
    add_vec(1, 8'h00, 4'd15, 1);
    add_vec(0, 8'h00, 4'd1, 1);
    add_vec(0, 8'h00, 4'd3, 1);
    add_vec(0, 8'h00, 4'd5, 1);
    add_vec(0, 8'h00, 4'd7, 1);
    add_vec(0, 8'h00, 4'd8, 0);

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("reset index", 32'(index), 32'd8);
    checkOutput("reset active", 32'(active), 32'd0);
    checkOutput("reset note_ready", 32'(note_ready), 32'd0);
    checkOutput("reset sample_tick", 32'(sample_tick), 32'd0);

    // First sample_tick arrives CLK_DIV cycles after reset drops.
    reset = 1'b0;
    n = 0;
    while (!sample_tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first tick delay", 32'(n), 32'(CLK_DIV));
    checkOutput("ready after reset", 32'(note_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    // Backpressure: two words back-to-back from the idle tick cycle.
    note_valid = 1'b1;
    note_tune  = 8'h10;
    checkOutput("bp ready first", 32'(note_ready), 32'd1);
    @(negedge clk);
    note_tune = 8'h18;
    low = 0;
    for (int i = 0; i < 10 && !note_ready; i++) begin
      low++;
      @(negedge clk);
    end
    checkOutput("bp ready low cycles", 32'(low), 32'd3);
    checkOutput("bp reopen on tick", 32'(sample_tick), 32'd1);
    checkOutput("bp first loaded index", 32'(index), 32'd8);
    checkOutput("bp first loaded active", 32'(active), 32'd1);
    @(negedge clk);
    note_valid = 1'b0;
    checkOutput("bp second accepted", 32'(note_ready), 32'd0);
    waitTick("bp tick a", seen);
    if (seen) checkOutput("bp step old tune", 32'(index), 32'd9);
    waitTick("bp tick b", seen);
    if (seen) checkOutput("bp step new tune", 32'(index), 32'd10);
    waitTick("bp tick c", seen);
    if (seen) checkOutput("bp reach 12", 32'(index), 32'd12);

    // Reset mid-run at index 12, with a freshly accepted word in pending.
    note_valid = 1'b1;
    note_tune  = 8'h30;
    @(negedge clk);
    note_valid = 1'b0;
    reset      = 1'b1;
    checkOutput("midrst ready comb", 32'(note_ready), 32'd0);
    @(negedge clk);
    checkOutput("midrst index", 32'(index), 32'd8);
    checkOutput("midrst active", 32'(active), 32'd0);
    checkOutput("midrst note_ready", 32'(note_ready), 32'd0);
    checkOutput("midrst sample_tick", 32'(sample_tick), 32'd0);
    reset = 1'b0;
    n = 0;
    while (!sample_tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst first tick delay", 32'(n), 32'(CLK_DIV));
    checkOutput("midrst pending dropped idx", 32'(index), 32'd8);
    checkOutput("midrst pending dropped act", 32'(active), 32'd0);

`ifdef PHASE_HARD_SYNC_EN
    // Hard sync in RUN zeroes the phase instead of stepping.
    sendNote(8'h10);
    waitTick("hs load", seen);
    if (seen) checkOutput("hs load index", 32'(index), 32'd8);
    waitTick("hs step", seen);
    if (seen) checkOutput("hs step index", 32'(index), 32'd9);
    hard_sync = 1'b1;
    waitTick("hs sync", seen);
    hard_sync = 1'b0;
    if (seen) checkOutput("hs sync index", 32'(index), 32'd0);
    waitTick("hs after", seen);
    if (seen) checkOutput("hs after index", 32'(index), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sawtooth_phase_gen.md
# sawtooth_phase_gen

Phase-accumulator stage directly upstream of the sawtooth look-up table: it turns a per-note tuning word into the 4-bit table index, stepping once per sample period. A handshaked note port loads new pitches without glitches. Stop requests park the index at mid-scale (index 8) rather than cutting mid-ramp, so note-off is click-free.

## Interface
- PHASE_W, 24: accumulator width; must be ≥ 5.
- CLK_DIV, 2083: clk cycles per sample period; must be ≥ 2.
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- note_valid  in  1  tuning word offered.
- note_ready  out  1  stage can accept a word.
- note_tune  in  PHASE_W  phase increment per sample; 0 means stop request.
- index  out  4  registered table index, equal to phase[PHASE_W-1 -: 4].
- sample_tick  out  1  one-cycle pulse; index is new in this cycle.
- active  out  1  high whenever the state is not IDLE.

## Operation
- A divider counter counts 0 to CLK_DIV-1 and wraps. The internal tick fires when the counter equals CLK_DIV-1.
- Note port:
  - note_ready = !pending_valid && !reset.
  - A transfer occurs on valid && ready; note_tune is captured into pending and pending_valid is set.
  - On the next internal tick, pending is consumed and pending_valid clears.
  - A word accepted on a tick cycle is consumed on the following tick.
- FSM states: IDLE, RUN, STOP. Rules below are evaluated on internal tick cycles only; the FSM is frozen otherwise.
  - IDLE: phase held at MID = 1<<(PHASE_W-1).
    - Pending nonzero: tune ← pending, go to RUN. Phase does not advance on this tick.
    - Pending zero: consumed, stay in IDLE.
  - RUN: phase ← phase + tune, modulo 2^PHASE_W.
    - Pending nonzero: tune replaced; the new tune is first used on the next tick.
    - Pending zero: go to STOP; tune is kept.
  - STOP: phase ← phase + tune.
    - If the phase MSB goes 0→1 on this step, force phase ← MID and go to IDLE.
    - Pending nonzero: tune loaded, go to RUN, phase advances normally. This wins over a simultaneous MSB crossing.
- Wrap-around from all-ones to 0 is normal in RUN and STOP and does not end STOP.
- All arithmetic is unsigned PHASE_W-bit; carry is discarded.

## Timing
- Reset values:
  - index = 4'd8, sample_tick = 0, active = 0, note_ready = 0.
  - Internally: phase = MID, tune = 0, pending_valid = 0, divider = 0, state IDLE.
- After reset, the first internal tick occurs CLK_DIV cycles after the first cycle with reset low.
- index, sample_tick and active register on the tick edge, so they are valid in the cycle after the internal tick. Latency from tick to output is 1 cycle.
- sample_tick is asserted for exactly one cycle per CLK_DIV cycles, in every state including IDLE.
- Note-to-pitch latency is at most 2 sample periods plus 1 cycle.
- Reset asserted mid-note takes effect on the next edge and discards pending and tune immediately.

## Configuration
- PHASE_HARD_SYNC_EN defined:
  - Adds input hard_sync (1 bit).
  - In RUN or STOP, hard_sync high on a tick sets phase to 0 instead of stepping.
  - A STOP→IDLE transition on that tick is suppressed.
  - It has no effect in IDLE and is ignored off-tick.
- PHASE_HARD_SYNC_EN undefined: the port is absent and phase always steps.

## Structure
- Package sound_pkg holds:
  - the state enum (IDLE/RUN/STOP);
  - the constant IDLE_INDEX = 4'd8;
  - the constant INDEX_W = 4, shared with the sawtooth table.
- One sub-module, sample_tick_div: a parameterised CLK_DIV counter with sync reset that outputs the internal tick.

## Test plan
All scenarios use PHASE_W = 8 and CLK_DIV = 4.
- Start: send tune 0x10 after reset → index reads 8 at load, then 9,10,…,15,0,1 on successive sample_ticks; active rises with the first sample_tick after load.
- Fractional: send tune 0x08 → index advances by 1 every 2 sample_ticks.
- Stop: send tune 0 while index = 3 under tune 0x10 → index 4,5,6,7 then 8; active falls on the same sample_tick; index stays 8.
- Backpressure: offer two words back-to-back → note_ready low from the cycle after the first transfer until the cycle after the next internal tick; the second word is then accepted.
- Cancel stop: send tune 0 then tune 0x20 before the MSB crossing → the FSM returns to RUN and index steps by 2.
- Reset mid-run at index 12 → next cycle index = 8, active = 0, note_ready = 0; first sample_tick 4 cycles after reset deasserts. With PHASE_HARD_SYNC_EN, a hard_sync pulse on a tick in RUN → index 0.
